uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter on the core's data store/load path, directly downstream of the load/store unit.
- Core stores bytes into a TX FIFO; an 8N1 serialiser drains the FIFO onto the `tx` pin.
- Status reads are combinational, so the single-cycle core completes a load in the same cycle.

---
 rtl/uart_tx_mmio_if.sv | 21 ++
 rtl/uart_tx_mmio.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_mmio_if.sv
// Store/load bus between the core's load/store unit and the UART transmitter.
// The core side is the master; the UART is the slave and answers loads combinationally.
interface uart_tx_mmio_if;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [31:0] rd_addr;
  logic        rd_hit;
  logic [31:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, wr_strb, rd_addr,
    input  rd_hit, rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_strb, rd_addr,
    output rd_hit, rd_data
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA fill a FIFO that the
// serialiser drains onto tx; STATUS reads are combinational for single-cycle loads.
module uart_tx_mmio #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           irq_empty
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]        state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg, baud_next;
  logic [2:0]        bit_idx_reg, bit_idx_next;
  logic [7:0]        shift_reg, shift_next;
  logic              tx_reg, tx_next;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              ovf_reg, ovf_next;
  logic              irq_empty_reg;
  logic [7:0]        mem [FIFO_DEPTH];

  logic wr_hit, push_req, push, pop, ovf_clr, fifo_full, fifo_empty, baud_last;
  logic [15:0] count_ext;
  logic unused_bits;

  assign unused_bits = ^{bus.wr_data[31:8], bus.wr_strb[3:1], bus.wr_addr[1:0], bus.rd_addr[1:0]};

  assign wr_hit     = (bus.wr_addr[31:4] == BASE_ADDR[31:4]);
  assign push_req   = bus.wr_en && wr_hit && (bus.wr_addr[3:2] == 2'd0) && bus.wr_strb[0];
  assign ovf_clr    = bus.wr_en && wr_hit && (bus.wr_addr[3:2] == 2'd1) && bus.wr_strb[0] && bus.wr_data[3];
  assign fifo_full  = (count_reg == CNT_FULL);
  assign fifo_empty = (count_reg == '0);
  // Fullness is judged before the edge, so a same-cycle pop never rescues a push into a full FIFO.
  assign push       = push_req && !fifo_full;
  assign pop        = (state_reg == S_IDLE) && !fifo_empty;
  assign baud_last  = (baud_reg == BAUD_LAST);

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + CNT_W'(1);
    else if (pop && !push)
      count_next = count_reg - CNT_W'(1);

    // A clear loses to an overflow landing in the same cycle.
    ovf_next = ovf_reg;
    if (ovf_clr)
      ovf_next = 1'b0;
    if (push_req && fifo_full)
      ovf_next = 1'b1;
  end

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    case (state_reg)
      S_IDLE: begin
        if (pop) begin
          shift_next = mem[rd_ptr_reg];
          baud_next  = '0;
          state_next = S_START;
        end
      end
      S_START: begin
        baud_next = baud_reg + BAUD_W'(1);
        if (baud_last) begin
          baud_next    = '0;
          bit_idx_next = 3'd0;
          state_next   = S_DATA;
        end
      end
      S_DATA: begin
        baud_next = baud_reg + BAUD_W'(1);
        if (baud_last) begin
          baud_next = '0;
          if (bit_idx_reg == 3'd7) begin
            state_next = S_STOP;
          end else begin
            shift_next   = {1'b0, shift_reg[7:1]};
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      default: begin
        baud_next = baud_reg + BAUD_W'(1);
        if (baud_last) begin
          baud_next  = '0;
          state_next = S_IDLE;
        end
      end
    endcase

    // Line level follows the state being entered, so the flop output never glitches.
    case (state_next)
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      baud_reg      <= '0;
      bit_idx_reg   <= 3'd0;
      shift_reg     <= 8'd0;
      tx_reg        <= 1'b1;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      ovf_reg       <= 1'b0;
      irq_empty_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      baud_reg      <= baud_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      tx_reg        <= tx_next;
      count_reg     <= count_next;
      ovf_reg       <= ovf_next;
      irq_empty_reg <= fifo_empty && (state_reg == S_IDLE);
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= bus.wr_data[7:0];
  end

  // At FIFO_DEPTH = 256 a full count wraps to 0 in the 8-bit field; the full bit disambiguates.
  assign count_ext = 16'(count_reg);

  always_comb begin
    bus.rd_hit  = (bus.rd_addr[31:4] == BASE_ADDR[31:4]);
    bus.rd_data = 32'd0;
    if (bus.rd_hit && (bus.rd_addr[3:2] == 2'd1))
      bus.rd_data = {16'd0, count_ext[7:0], 4'd0, ovf_reg, (state_reg != S_IDLE), fifo_empty, fifo_full};
  end

  assign tx        = tx_reg;
  assign irq_empty = irq_empty_reg;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomised scoreboard bench for uart_tx_mmio: a queue-and-frame-timing model predicts
// accepted bytes and their start edges; a line monitor decodes tx and checks every frame.
module tb_uart_tx_mmio;
  localparam int          C    = 4;
  localparam int          D    = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx, irq_empty;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .tx(tx), .irq_empty(irq_empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents, frame timing in edge numbers, sticky overflow.
  logic [7:0] m_fifo[$];
  logic [7:0] exp_q[$];
  int         start_q[$];
  logic       m_ovf = 1'b0;
  logic       m_irq = 1'b1;
  int         edge_no = -1;
  int         busy_end = -1;
  int         next_free = 0;

  always @(posedge clk) begin : model
    logic hit, push_req, clr, full, pre_busy;
    edge_no++;
    if (!rst_n) begin
      m_fifo.delete();
      exp_q.delete();
      start_q.delete();
      m_ovf = 1'b0;
      m_irq = 1'b1;
      busy_end = -1;
      next_free = 0;
    end else begin
      pre_busy = (edge_no - 1) < busy_end;
      m_irq    = (m_fifo.size() == 0) && !pre_busy;
      full     = (m_fifo.size() == D);
      hit      = (bus.wr_addr[31:4] == BASE[31:4]);
      push_req = bus.wr_en && hit && (bus.wr_addr[3:2] == 2'd0) && bus.wr_strb[0];
      clr      = bus.wr_en && hit && (bus.wr_addr[3:2] == 2'd1) && bus.wr_strb[0] && bus.wr_data[3];
      if (edge_no >= next_free && m_fifo.size() > 0) begin
        void'(m_fifo.pop_front());
        start_q.push_back(edge_no);
        busy_end  = edge_no + 10 * C;
        next_free = busy_end + 1;
      end
      if (clr)
        m_ovf = 1'b0;
      if (push_req) begin
        if (full) begin
          m_ovf = 1'b1;
        end else begin
          m_fifo.push_back(bus.wr_data[7:0]);
          exp_q.push_back(bus.wr_data[7:0]);
        end
      end
    end
  end

  function automatic logic [31:0] m_read(input logic [31:0] addr, output logic hit);
    logic [7:0] cnt;
    logic busy;
    hit  = (addr[31:4] == BASE[31:4]);
    cnt  = 8'(m_fifo.size());
    busy = edge_no < busy_end;
    if (hit && addr[3:2] == 2'd1)
      return {16'd0, cnt, 4'd0, m_ovf, busy, (cnt == 8'd0), (m_fifo.size() == D)};
    return 32'd0;
  endfunction

  // Line monitor: one comparison per decoded frame plus its start-edge timing.
  logic       mon_active = 1'b0;
  logic       mon_bad = 1'b0;
  int         mon_cnt = 0;
  int         mon_err = 0;
  logic [7:0] mon_byte = 8'd0;

  always @(negedge clk) begin : monitor
    int idx;
    logic bitv;
    if (!rst_n) begin
      mon_active = 1'b0;
      mon_bad    = 1'b0;
    end else begin
      if (mon_bad && tx === 1'b1)
        mon_bad = 1'b0;
      if (!mon_active && !mon_bad && tx !== 1'b1) begin
        if (exp_q.size() == 0 || start_q.size() == 0) begin
          chk("unexpected_start", {31'd0, tx}, 32'd1);
          mon_bad = 1'b1;
        end else begin
          mon_byte   = exp_q.pop_front();
          chk("start_edge", 32'(edge_no), 32'(start_q.pop_front()));
          mon_active = 1'b1;
          mon_cnt    = 0;
          mon_err    = 0;
        end
      end
      if (mon_active) begin
        idx = mon_cnt / C;
        if (idx == 0)      bitv = 1'b0;
        else if (idx == 9) bitv = 1'b1;
        else               bitv = mon_byte[idx-1];
        if (tx !== bitv)
          mon_err++;
        if (mon_cnt == 10 * C - 1) begin
          $display("frame %02h ended at edge %0d, bit errors %0d", mon_byte, edge_no, mon_err);
          chk($sformatf("frame_%02h", mon_byte), 32'(mon_err), 32'd0);
          mon_active = 1'b0;
        end else begin
          mon_cnt++;
        end
      end
    end
  end

  // One bus cycle: drive at negedge, then check the combinational read against the model.
  task automatic cyc(input logic en, input logic [31:0] wa, input logic [31:0] wd,
                     input logic [3:0] ws, input logic [31:0] ra);
    logic [31:0] exp_d;
    logic exp_hit;
    @(negedge clk);
    bus.wr_en   = en;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.wr_strb = ws;
    bus.rd_addr = ra;
    #1;
    exp_d = m_read(ra, exp_hit);
    chk("rd_hit", {31'd0, bus.rd_hit}, {31'd0, exp_hit});
    chk("rd_data", bus.rd_data, exp_d);
    chk("irq_empty", {31'd0, irq_empty}, {31'd0, m_irq});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 32'd0, 32'd0, 4'd0, BASE + 32'd4);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || m_fifo.size() != 0 || mon_active) && k < 2000) begin
      idle(1);
      k++;
    end
    chk("drain_in_budget", 32'(k < 2000), 32'd1);
    idle(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wa, ra, wd;
    logic [3:0]  ws;
    int r;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_strb = '0; bus.rd_addr = BASE + 32'd4;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_rd_hit", {31'd0, bus.rd_hit}, 32'd1);
    chk("reset_status", bus.rd_data, 32'h0000_0002);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_irq", {31'd0, irq_empty}, 32'd1);

    // Single frame, then the idle/irq state it leaves behind.
    cyc(1'b1, BASE, 32'h0000_0055, 4'b0001, BASE + 32'd4);
    idle(46);
    chk("after_frame_status", bus.rd_data, 32'h0000_0002);
    chk("after_frame_irq", {31'd0, irq_empty}, 32'd1);

    // Store with lane 0 disabled is not a push.
    cyc(1'b1, BASE, 32'h0000_00AB, 4'b1110, BASE + 32'd4);
    idle(3);
    chk("strb_no_push_status", bus.rd_data, 32'h0000_0002);
    chk("strb_no_push_tx", {31'd0, tx}, 32'd1);

    // Overflow: six back-to-back stores into a depth-4 FIFO.
    for (int i = 0; i < 6; i++)
      cyc(1'b1, BASE, 32'hA0 + 32'(i), 4'b0001, BASE + 32'd4);
    idle(1);
    chk("overflow_status", bus.rd_data, 32'h0000_040D);
    cyc(1'b1, BASE + 32'd4, 32'h0000_0008, 4'b0001, BASE + 32'd4);
    idle(1);
    chk("ovf_clear_status", bus.rd_data, 32'h0000_0405);
    drain();

    // Reserved and out-of-window reads.
    cyc(1'b1, BASE + 32'd8, 32'hFFFF_FFFF, 4'b1111, BASE + 32'd8);
    idle(1);
    bus.rd_addr = BASE + 32'd8; #1;
    chk("reserved_rd_data", bus.rd_data, 32'd0);
    chk("reserved_rd_hit", {31'd0, bus.rd_hit}, 32'd1);
    bus.rd_addr = BASE + 32'd16; #1;
    chk("miss_rd_hit", {31'd0, bus.rd_hit}, 32'd0);
    chk("miss_rd_data", bus.rd_data, 32'd0);
    bus.rd_addr = BASE; #1;
    chk("txdata_rd_data", bus.rd_data, 32'd0);

    // Randomised traffic across all registers and out-of-window addresses.
    for (int i = 0; i < 500; i++) begin
      r  = $urandom_range(0, 9);
      wd = $urandom;
      ws = 4'($urandom);
      if ($urandom_range(0, 3) != 0) ws[0] = 1'b1;
      case (r)
        0, 1, 2, 3: wa = BASE + 32'($urandom_range(0, 3));
        4:          wa = BASE + 32'd4 + 32'($urandom_range(0, 3));
        5:          wa = BASE + 32'd8 + 32'($urandom_range(0, 7));
        6:          wa = BASE + 32'h10 * 32'($urandom_range(1, 200));
        default:    wa = 32'd0;
      endcase
      case ($urandom_range(0, 4))
        0:       ra = BASE;
        1, 2:    ra = BASE + 32'd4 + 32'($urandom_range(0, 3));
        3:       ra = BASE + 32'd8 + 32'($urandom_range(0, 7));
        default: ra = $urandom;
      endcase
      cyc(r <= 6, wa, wd, ws, ra);
    end
    drain();

    // Asynchronous reset in the middle of a frame of zeros.
    cyc(1'b1, BASE, 32'h0000_0000, 4'b0001, BASE + 32'd4);
    idle(12);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_tx", {31'd0, tx}, 32'd1);
    chk("async_reset_irq", {31'd0, irq_empty}, 32'd1);
    bus.rd_addr = BASE + 32'd4; #1;
    chk("async_reset_status", bus.rd_data, 32'h0000_0002);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(60);
    chk("post_reset_status", bus.rd_data, 32'h0000_0002);
    chk("post_reset_tx", {31'd0, tx}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
